pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RESET_PC, default 16'h0000, PC loaded by reset (bit0 SHALL be 0).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset.
REQ-005 imem_req_valid  out  1  fetch request valid.
REQ-006 imem_req_ready  in  1  instruction memory accepts request.
REQ-007 imem_addr  out  16  fetch byte address.
REQ-008 imem_rsp_valid  in  1  fetch data valid (one per accepted request, latency >=1).
REQ-009 imem_rsp_data  in  16  fetched instruction word.
REQ-010 instr_valid  out  1  instruction offered to decode.
REQ-011 instr_ready  in  1  decode accepts instruction.
REQ-012 instr / instr_pc  out  16 / 16  offered instruction and its address.
REQ-013 resolve_valid  in  1  execute stage presents a resolved control-flow instruction.
REQ-014 do_branch / do_jump  in  1 / 1  branch / jump control from decode.
REQ-015 branch_ctrl  in  3  branch func field.
REQ-016 rs1_val / rs2_val  in  16 / 16  compare operands.
REQ-017 target  in  16  ALU-computed redirect address.
REQ-018 flush  out  1  one-cycle pulse: kill younger in-flight instructions.
REQ-019 misalign_err  out  1  one-cycle pulse: target bit0 was set.

Function
REQ-020 States: REQ, WAIT, HOLD, DRAIN; at most one outstanding fetch.
REQ-021 REQ: imem_req_valid=1, imem_addr=pc; on imem_req_ready -> WAIT.
REQ-022 WAIT: on imem_rsp_valid capture data into instr, pc into instr_pc, pc<=pc+2 -> HOLD.
REQ-023 HOLD: instr_valid=1; instr/instr_pc stable until accepted; on instr_ready -> REQ (next fetch issued the following cycle).
REQ-024 PC arithmetic modulo 2^16: 16'hFFFE+2 = 16'h0000.
REQ-025 Branch conditions (signed unless noted): 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU unsigned, 111 BGEU unsigned; 010/011 never taken.
REQ-026 redirect = resolve_valid & (do_jump | (do_branch & condition true)); do_jump wins if both set.
REQ-027 On redirect: pc<={target[15:1],1'b0}; flush=1 same cycle; misalign_err=target[0] same cycle.
REQ-028 Redirect in REQ: current request dropped; request at new pc next cycle, even if imem_req_ready was high the same cycle (that accepted request is then handled as in WAIT).
REQ-029 Redirect in WAIT (or REQ with accept): -> DRAIN; the pending response is discarded; then -> REQ.
REQ-030 Redirect in WAIT coinciding with imem_rsp_valid: response discarded -> REQ directly.
REQ-031 Redirect in HOLD: held instruction dropped (instr_valid=0 next cycle) even if instr_ready same cycle; -> REQ.
REQ-032 Redirect in DRAIN: pc updated, stay DRAIN.
REQ-033 instr_valid SHALL never be high in REQ, WAIT, DRAIN.

Reset
REQ-034 rst: state=REQ, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, flush=0, misalign_err=0; imem_req_valid=0 during rst, 1 the cycle after.
REQ-035 rst mid-operation: pending response ignored (no DRAIN); memory side SHALL tolerate a stray response.

Structure
REQ-036 Shared package octa16_pkg: branch func encodings, PC_STEP=2, state enum.
REQ-037 Sub-module branch_cmp: combinational condition evaluator (branch_ctrl, rs1_val, rs2_val -> taken).

Verification
REQ-038 Reset, ready always 1, rsp latency 1, instr_ready 1 -> addresses 0000,0002,0004; instr_pc matches.
REQ-039 BLT rs1=16'hFFFF, rs2=1 -> taken, flush pulse, next imem_addr=target; BLTU same operands -> not taken, no flush.
REQ-040 Jump target 16'h0101 during WAIT -> misalign_err=1, response dropped, next imem_addr=16'h0100.
REQ-041 RESET_PC=16'hFFFE -> second fetch at 16'h0000.
REQ-042 HOLD with instr_ready=0 for 5 cycles -> instr stable; redirect with instr_ready=1 -> instruction dropped, fetch at target.
REQ-043 rst asserted during WAIT -> restart fetch at RESET_PC; stray response ignored.

Source files
------------

// File: rtl/octa16_pkg.sv
// Shared definitions for the octa16 fetch front end: data width, PC step,
// branch function encodings, sequencer states and the captured fetch payload.
package octa16_pkg;

  localparam int unsigned XLEN = 16;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(2);

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_func_e;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_e;

  // Instruction word together with the address it was fetched from
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator.
// Ports: branch_ctrl (func field), rs1_val/rs2_val (operands) -> taken.
// Encodings 010/011 are reserved and never taken.
module branch_cmp
  import octa16_pkg::*;
(
  input  logic [2:0]      branch_ctrl,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            taken
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1_val == rs2_val);
  assign lt_s = ($signed(rs1_val) < $signed(rs2_val));
  assign lt_u = (rs1_val < rs2_val);

  always_comb begin
    taken = 1'b0;
    case (branch_ctrl)
      BR_BEQ:  taken = eq;
      BR_BNE:  taken = !eq;
      BR_BLT:  taken = lt_s;
      BR_BGE:  taken = !lt_s;
      BR_BLTU: taken = lt_u;
      BR_BGEU: taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: issues one instruction fetch at a time, holds the
// returned word for decode, and redirects on resolved jumps / taken branches.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr fetch request channel
//   imem_rsp_valid, imem_rsp_data   fetch response (one per accepted request)
//   instr_valid/ready, instr, instr_pc  instruction offered to decode
//   resolve_valid, do_branch, do_jump, branch_ctrl, rs1_val, rs2_val, target
//                                   control-flow resolution from execute
//   flush, misalign_err             same-cycle pulses on redirect
module pc_sequencer
  import octa16_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            resolve_valid,
  input  logic            do_branch,
  input  logic            do_jump,
  input  logic [2:0]      branch_ctrl,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] target,
  output logic            flush,
  output logic            misalign_err
);

  seq_state_e      state_q;
  seq_state_e      state_d;
  logic [XLEN-1:0] pc_q;
  fetch_pkt_t      pkt_q;
  logic            instr_valid_q;
  logic            taken;
  logic            redirect;
  logic            capture;
  logic [XLEN-1:0] redirect_pc;

  branch_cmp u_branch_cmp (
    .branch_ctrl (branch_ctrl),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .taken       (taken)
  );

  // Jump wins over branch simply because either one redirects to target
  assign redirect    = !rst && resolve_valid && (do_jump || (do_branch && taken));
  assign redirect_pc = {target[XLEN-1:1], 1'b0};
  assign capture     = (state_q == ST_WAIT) && imem_rsp_valid && !redirect;

  assign imem_addr   = pc_q;
  assign instr       = pkt_q.instr;
  assign instr_pc    = pkt_q.pc;
  assign instr_valid = instr_valid_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      // An accepted request still owes a response, so a redirect must drain it
      ST_REQ: begin
        if (imem_req_ready) begin
          state_d = redirect ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = redirect ? ST_REQ : ST_HOLD;
        end else if (redirect) begin
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (redirect || instr_ready) begin
          state_d = ST_REQ;
        end
      end
      // A redirect here only moves pc; leaving still waits for the stale response
      ST_DRAIN: begin
        if (imem_rsp_valid) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  // Output decode
  always_comb begin
    imem_req_valid = (state_q == ST_REQ) && !rst;
    flush          = redirect;
    misalign_err   = redirect && target[0];
  end

  // PC and held-instruction datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      pkt_q         <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      instr_valid_q <= (state_d == ST_HOLD);
      if (redirect) begin
        pc_q <= redirect_pc;
      end else if ((state_q == ST_WAIT) && imem_rsp_valid) begin
        pc_q <= pc_q + PC_STEP;
      end
      if (capture) begin
        pkt_q <= '{instr: imem_rsp_data, pc: pc_q};
      end
    end
  end

endmodule
